// File: rtl/hfrv_mem_arbiter_if.sv
// Bundle of requester, RAM and counter signals around hfrv_mem_arbiter.
// slave = arbiter side, master = requesters plus RAM model side.
interface hfrv_mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
);
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wbe;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;

    logic              dbg_req;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic [3:0]        dbg_wbe;
    logic [31:0]       dbg_rdata;
    logic              dbg_ack;
    logic              dbg_err;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wbe;
    logic [31:0]       mem_rdata;

    logic [CNT_W-1:0]  cpu_grants;
    logic [CNT_W-1:0]  dbg_grants;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wbe,
        input  dbg_req, dbg_addr, dbg_wdata, dbg_wbe,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, cpu_err,
        output dbg_rdata, dbg_ack, dbg_err,
        output mem_en, mem_addr, mem_wdata, mem_wbe,
        output cpu_grants, dbg_grants
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wbe,
        output dbg_req, dbg_addr, dbg_wdata, dbg_wbe,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        input  dbg_rdata, dbg_ack, dbg_err,
        input  mem_en, mem_addr, mem_wdata, mem_wbe,
        input  cpu_grants, dbg_grants
    );
endinterface

// File: rtl/hfrv_mem_arbiter.sv
// Two-requester arbiter for the single-port RAM: mem_en the cycle after the grant edge, ack two cycles later
// (error ack one cycle after grant). Requesters hold req with stable fields until ack; one access per 3 cycles.
module hfrv_mem_arbiter #(
    parameter logic [31:0] RAM_BASE   = 32'h4000_0000,
    parameter logic [31:0] RAM_SIZE   = 32'h0001_0000,
    parameter int          ADDR_W     = 14,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hfrv_mem_arbiter_if.slave    io_bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    localparam logic [32:0] LP_END = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE};

    state_t            r_state;
    logic              r_sel;
    logic              r_last;
    logic              r_err;
    logic              r_read;
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_wbe;
    logic              r_cpu_ack;
    logic              r_cpu_err;
    logic [31:0]       r_cpu_rdata;
    logic              r_dbg_ack;
    logic              r_dbg_err;
    logic [31:0]       r_dbg_rdata;
    logic [CNT_W-1:0]  r_cpu_cnt;
    logic [CNT_W-1:0]  r_dbg_cnt;

    logic              w_cpu_win;
    logic              w_dbg_win;
    logic              w_win_in;
    logic [31:0]       w_win_addr;
    logic [31:0]       w_win_wdata;
    logic [3:0]        w_win_wbe;
    logic [31:0]       w_win_off;
    logic [ADDR_W-1:0] w_win_word;
    logic [31:0]       w_resp_rdata;

    // r_last is 1 when dbg was served last, so under round-robin cpu wins a tie then.
    always_comb begin
        w_cpu_win   = io_bus.cpu_req && (!io_bus.dbg_req || FIXED_PRIO || r_last);
        w_dbg_win   = io_bus.dbg_req && !w_cpu_win;
        w_win_addr  = w_dbg_win ? io_bus.dbg_addr  : io_bus.cpu_addr;
        w_win_wdata = w_dbg_win ? io_bus.dbg_wdata : io_bus.cpu_wdata;
        w_win_wbe   = w_dbg_win ? io_bus.dbg_wbe   : io_bus.cpu_wbe;
        w_win_in    = (w_win_addr >= RAM_BASE) && ({1'b0, w_win_addr} < LP_END);
        w_win_off   = w_win_addr - RAM_BASE;
        w_win_word  = ADDR_W'(w_win_off >> 2);
        w_resp_rdata = (!r_err && r_read) ? io_bus.mem_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_err       <= 1'b0;
            r_read      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wbe   <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_err   <= 1'b0;
            r_dbg_rdata <= '0;
            r_cpu_cnt   <= '0;
            r_dbg_cnt   <= '0;
        end else begin
            r_mem_en    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_err   <= 1'b0;
            r_dbg_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cpu_win || w_dbg_win) begin
                        r_sel  <= w_dbg_win;
                        r_read <= (w_win_wbe == 4'd0);
                        if (w_win_in) begin
                            r_err       <= 1'b0;
                            r_mem_en    <= 1'b1;
                            r_mem_addr  <= w_win_word;
                            r_mem_wdata <= w_win_wdata;
                            r_mem_wbe   <= w_win_wbe;
                            r_state     <= ST_ACCESS;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_wbe   <= '0;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    // RAM read data lands this cycle, so it is captured into rdata with the ack.
                    if (r_sel) begin
                        r_dbg_ack   <= 1'b1;
                        r_dbg_err   <= r_err;
                        r_dbg_rdata <= w_resp_rdata;
                        if (r_dbg_cnt != '1) r_dbg_cnt <= r_dbg_cnt + CNT_W'(1);
                    end else begin
                        r_cpu_ack   <= 1'b1;
                        r_cpu_err   <= r_err;
                        r_cpu_rdata <= w_resp_rdata;
                        if (r_cpu_cnt != '1) r_cpu_cnt <= r_cpu_cnt + CNT_W'(1);
                    end
                    r_last  <= r_sel;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.mem_en     = r_mem_en;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;
    assign io_bus.mem_wbe    = r_mem_wbe;
    assign io_bus.cpu_ack    = r_cpu_ack;
    assign io_bus.cpu_err    = r_cpu_err;
    assign io_bus.cpu_rdata  = r_cpu_rdata;
    assign io_bus.dbg_ack    = r_dbg_ack;
    assign io_bus.dbg_err    = r_dbg_err;
    assign io_bus.dbg_rdata  = r_dbg_rdata;
    assign io_bus.cpu_grants = r_cpu_cnt;
    assign io_bus.dbg_grants = r_dbg_cnt;
endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Directed bench for hfrv_mem_arbiter: round-robin instance with RAM model,
// plus a fixed-priority instance and a 2-bit-counter instance.
module tb_hfrv_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hfrv_mem_arbiter_if #(.ADDR_W(14), .CNT_W(16)) if0 ();
    hfrv_mem_arbiter_if #(.ADDR_W(14), .CNT_W(16)) if1 ();
    hfrv_mem_arbiter_if #(.ADDR_W(14), .CNT_W(2))  if2 ();

    hfrv_mem_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(16)) u_dut (.clk(clk), .reset(reset), .io_bus(if0));
    hfrv_mem_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(16)) u_fix (.clk(clk), .reset(reset), .io_bus(if1));
    hfrv_mem_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(2))  u_sat (.clk(clk), .reset(reset), .io_bus(if2));

    // RAM model for the main instance: reloaded with a known pattern whenever reset is high.
    logic [31:0] ram0 [0:16383];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16384; i++) ram0[i] <= 32'h1000_0000 | i;
            ram0[4] <= 32'hDEAD_BEEF;
            if0.mem_rdata <= 32'd0;
        end else if (if0.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (if0.mem_wbe[b]) ram0[if0.mem_addr][8*b +: 8] <= if0.mem_wdata[8*b +: 8];
            if0.mem_rdata <= ram0[if0.mem_addr];
        end
    end
    always @(posedge clk) begin
        if (reset) if1.mem_rdata <= 32'd0;
        else if (if1.mem_en) if1.mem_rdata <= {18'd0, if1.mem_addr};
        if (reset) if2.mem_rdata <= 32'd0;
        else if (if2.mem_en) if2.mem_rdata <= {18'd0, if2.mem_addr};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          dbg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [13:0] exp_maddr;
    } vec_t;

    vec_t vecs [11];

    logic [31:0] t_rdata;
    logic        t_err;
    int          t_ack_lat;
    int          t_en_lat;
    logic [13:0] t_maddr;
    logic [3:0]  t_mwbe;
    bit          t_stray;

    task automatic do_txn(input bit dbg, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wbe, output logic [31:0] rdata, output logic err,
                          output int ack_lat, output int en_lat, output logic [13:0] maddr,
                          output logic [3:0] mwbe, output bit stray);
        rdata = 32'd0; err = 1'b0; ack_lat = -1; en_lat = -1; maddr = '0; mwbe = '0; stray = 1'b0;
        if (dbg) begin
            if0.dbg_addr = addr; if0.dbg_wdata = wdata; if0.dbg_wbe = wbe; if0.dbg_req = 1'b1;
        end else begin
            if0.cpu_addr = addr; if0.cpu_wdata = wdata; if0.cpu_wbe = wbe; if0.cpu_req = 1'b1;
        end
        for (int c = 1; c <= 10; c++) begin
            step();
            if (if0.mem_en) begin
                if (en_lat < 0) begin en_lat = c; maddr = if0.mem_addr; mwbe = if0.mem_wbe; end
                else stray = 1'b1;
            end
            if (dbg ? (if0.cpu_ack || if0.cpu_err || if0.cpu_rdata != 0)
                    : (if0.dbg_ack || if0.dbg_err || if0.dbg_rdata != 0)) stray = 1'b1;
            if (dbg ? if0.dbg_ack : if0.cpu_ack) begin
                ack_lat = c;
                rdata = dbg ? if0.dbg_rdata : if0.cpu_rdata;
                err   = dbg ? if0.dbg_err   : if0.cpu_err;
                break;
            end
        end
        if0.cpu_req = 1'b0;
        if0.dbg_req = 1'b0;
    endtask

    int  order [8];
    int  tstamp [8];
    int  n_gr;
    int  n_dbg_ack;
    int  exp_cpu;
    int  exp_dbg;
    bit  got;

    initial begin
        if0.cpu_req = 0; if0.cpu_addr = 0; if0.cpu_wdata = 0; if0.cpu_wbe = 0;
        if0.dbg_req = 0; if0.dbg_addr = 0; if0.dbg_wdata = 0; if0.dbg_wbe = 0;
        if1.cpu_req = 0; if1.cpu_addr = 0; if1.cpu_wdata = 0; if1.cpu_wbe = 0;
        if1.dbg_req = 0; if1.dbg_addr = 0; if1.dbg_wdata = 0; if1.dbg_wbe = 0;
        if2.cpu_req = 0; if2.cpu_addr = 0; if2.cpu_wdata = 0; if2.cpu_wbe = 0;
        if2.dbg_req = 0; if2.dbg_addr = 0; if2.dbg_wdata = 0; if2.dbg_wbe = 0;

        vecs[0]  = '{1'b0, 32'h4000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 14'd4};
        vecs[1]  = '{1'b1, 32'h4000_0008, 32'h1234_5678, 4'h3, 32'h0,         1'b0, 14'd2};
        vecs[2]  = '{1'b0, 32'h4000_0008, 32'h0,         4'h0, 32'h1000_5678, 1'b0, 14'd2};
        vecs[3]  = '{1'b0, 32'h3FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 14'd0};
        vecs[4]  = '{1'b0, 32'h4001_0000, 32'h0,         4'h0, 32'h0,         1'b1, 14'd0};
        vecs[5]  = '{1'b0, 32'h4000_FFFF, 32'h0,         4'h0, 32'h1000_3FFF, 1'b0, 14'h3FFF};
        vecs[6]  = '{1'b1, 32'h4000_0000, 32'hAABB_CCDD, 4'hF, 32'h0,         1'b0, 14'd0};
        vecs[7]  = '{1'b1, 32'h4000_0001, 32'h0,         4'h0, 32'hAABB_CCDD, 1'b0, 14'd0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 14'd0};
        vecs[9]  = '{1'b0, 32'h4000_FFFC, 32'h7700_0000, 4'h8, 32'h0,         1'b0, 14'h3FFF};
        vecs[10] = '{1'b0, 32'h4000_FFFC, 32'h0,         4'h0, 32'h7700_3FFF, 1'b0, 14'h3FFF};

        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        check("rst_mem_en",     32'(if0.mem_en), 32'd0);
        check("rst_mem_addr",   32'(if0.mem_addr), 32'd0);
        check("rst_mem_wbe",    32'(if0.mem_wbe), 32'd0);
        check("rst_cpu_ack",    32'(if0.cpu_ack), 32'd0);
        check("rst_cpu_rdata",  if0.cpu_rdata, 32'd0);
        check("rst_dbg_ack",    32'(if0.dbg_ack), 32'd0);
        check("rst_cpu_grants", 32'(if0.cpu_grants), 32'd0);
        check("rst_dbg_grants", 32'(if0.dbg_grants), 32'd0);

        exp_cpu = 0; exp_dbg = 0;
        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i].dbg, vecs[i].addr, vecs[i].wdata, vecs[i].wbe,
                   t_rdata, t_err, t_ack_lat, t_en_lat, t_maddr, t_mwbe, t_stray);
            if (vecs[i].dbg) exp_dbg++; else exp_cpu++;
            check($sformatf("v%0d_ack_lat", i), 32'(t_ack_lat), vecs[i].exp_err ? 32'd2 : 32'd3);
            check($sformatf("v%0d_err", i), 32'(t_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i), t_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_en_lat", i), 32'(t_en_lat), vecs[i].exp_err ? 32'hFFFF_FFFF : 32'd1);
            check($sformatf("v%0d_other_side", i), 32'(t_stray), 32'd0);
            if (!vecs[i].exp_err) begin
                check($sformatf("v%0d_mem_addr", i), 32'(t_maddr), 32'(vecs[i].exp_maddr));
                check($sformatf("v%0d_mem_wbe", i), 32'(t_mwbe), 32'(vecs[i].wbe));
            end
        end
        check("vec_cpu_grants", 32'(if0.cpu_grants), 32'(exp_cpu));
        check("vec_dbg_grants", 32'(if0.dbg_grants), 32'(exp_dbg));

        // Round-robin with both requesters held high from reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        if0.cpu_addr = 32'h4000_0020; if0.cpu_wbe = 4'h0;
        if0.dbg_addr = 32'h4000_0040; if0.dbg_wbe = 4'h0;
        if0.cpu_req = 1'b1; if0.dbg_req = 1'b1;
        n_gr = 0;
        for (int c = 1; c <= 60 && n_gr < 8; c++) begin
            step();
            if (if0.cpu_ack && if0.dbg_ack) check("rr_dual_ack", 32'd1, 32'd0);
            else if (if0.cpu_ack || if0.dbg_ack) begin
                order[n_gr] = if0.dbg_ack ? 1 : 0;
                tstamp[n_gr] = c;
                n_gr++;
            end
        end
        if0.cpu_req = 1'b0; if0.dbg_req = 1'b0;
        check("rr_grant_count", 32'(n_gr), 32'd8);
        for (int k = 0; k < n_gr; k++) begin
            check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));
            if (k > 0) check($sformatf("rr_spacing%0d", k), 32'(tstamp[k] - tstamp[k-1]), 32'd3);
        end
        check("rr_first_lat", 32'(tstamp[0]), 32'd3);
        check("rr_cpu_grants", 32'(if0.cpu_grants), 32'd4);
        check("rr_dbg_grants", 32'(if0.dbg_grants), 32'd4);
        step();

        // Fixed priority: cpu served once alone, then both held; dbg must starve.
        if1.cpu_addr = 32'h4000_0100; if1.dbg_addr = 32'h4000_0200;
        if1.cpu_req = 1'b1;
        n_gr = 0; n_dbg_ack = 0;
        for (int c = 1; c <= 60 && n_gr < 7; c++) begin
            step();
            if (if1.dbg_ack) n_dbg_ack++;
            if (if1.cpu_ack) begin
                n_gr++;
                if1.dbg_req = 1'b1;
            end
        end
        if1.cpu_req = 1'b0; if1.dbg_req = 1'b0;
        check("fix_cpu_acks", 32'(n_gr), 32'd7);
        check("fix_dbg_acks", 32'(n_dbg_ack), 32'd0);
        check("fix_cpu_grants", 32'(if1.cpu_grants), 32'd7);
        check("fix_dbg_grants", 32'(if1.dbg_grants), 32'd0);

        // Reset asserted while an access is in ACCESS.
        step();
        if0.dbg_addr = 32'h4000_0010; if0.dbg_wbe = 4'h0; if0.dbg_req = 1'b1;
        step();
        check("ra_mem_en_before", 32'(if0.mem_en), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ra_mem_en",     32'(if0.mem_en), 32'd0);
        check("ra_mem_addr",   32'(if0.mem_addr), 32'd0);
        check("ra_dbg_ack",    32'(if0.dbg_ack), 32'd0);
        check("ra_cpu_ack",    32'(if0.cpu_ack), 32'd0);
        check("ra_dbg_grants", 32'(if0.dbg_grants), 32'd0);
        check("ra_cpu_grants", 32'(if0.cpu_grants), 32'd0);
        t_ack_lat = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) check("ra_no_ack_after_reset", 32'(if0.dbg_ack), 32'd0);
            if (if0.dbg_ack) begin
                t_ack_lat = c;
                check("ra_reserve_rdata", if0.dbg_rdata, 32'hDEAD_BEEF);
                check("ra_reserve_err", 32'(if0.dbg_err), 32'd0);
                break;
            end
        end
        if0.dbg_req = 1'b0;
        check("ra_reserve_lat", 32'(t_ack_lat), 32'd3);
        check("ra_reserve_grants", 32'(if0.dbg_grants), 32'd1);

        // 2-bit counter saturation.
        if2.cpu_addr = 32'h4000_0004; if2.cpu_wbe = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            got = 1'b0;
            if2.cpu_req = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                step();
                if (if2.cpu_ack) begin got = 1'b1; break; end
            end
            if2.cpu_req = 1'b0;
            check($sformatf("sat_ack%0d", k), 32'(got), 32'd1);
            check($sformatf("sat_cnt%0d", k), 32'(if2.cpu_grants), (k > 3) ? 32'd3 : 32'(k));
        end
        check("sat_rdata", if2.cpu_rdata, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
